// File: rtl/jtframe_nvram_dump.sv
// Serves io-controller NVRAM byte reads from a 16-bit game RAM port, with a one-deep request slot.
// Define JTFRAME_NVRAM_CACHE_EN to add a one-word read cache that short-cuts repeated word reads.
module jtframe_nvram_dump #(
   parameter int         AW   = 13,
   parameter logic [7:0] FILL = 8'hFF
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          ioctl_ram,
   input  logic [24:0]   ioctl_addr,
   input  logic          ioctl_rd,
   output logic [7:0]    ioctl_data2sd,
   output logic          dump_ok,
   output logic          dump_ovf,
   output logic [AW-2:0] ram_addr,
   output logic          ram_rd,
   input  logic          ram_ack,
   input  logic          ram_dok,
   input  logic [15:0]   ram_din
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_SERVE} state_t;

   state_t        state_q, state_d;
   logic [7:0]    data_q, data_d;
   logic          ok_q, ok_d;
   logic          ovf_q, ovf_d;
   logic [AW-2:0] raddr_q, raddr_d;
   logic          rd_q, rd_d;
   logic          bsel_q, bsel_d;
   logic          pend_q, pend_d;
   logic [24:0]   pend_addr_q, pend_addr_d;
   logic          ram_en_q;

   logic          strobe_s;
   logic          busy_s;
   logic          take_s;
   logic [24:0]   take_addr_s;
   logic          oor_s;
   logic          drop_s;

`ifdef JTFRAME_NVRAM_CACHE_EN
   logic          cvalid_q, cvalid_d;
   logic [AW-2:0] ctag_q, ctag_d;
   logic [15:0]   cdata_q, cdata_d;
   logic          hit_s;
`endif

   assign strobe_s    = ioctl_rd & ioctl_ram;
   assign busy_s      = (state_q != ST_IDLE);
   // A waiting entry always wins over a strobe arriving in the same IDLE cycle
   assign take_s      = pend_q | strobe_s;
   assign take_addr_s = pend_q ? pend_addr_q : ioctl_addr;
   assign oor_s       = (take_addr_s >> AW) != 25'd0;
   assign drop_s      = busy_s & strobe_s & pend_q;

`ifdef JTFRAME_NVRAM_CACHE_EN
   assign hit_s = cvalid_q && (ctag_q == take_addr_s[AW-1:1]);
`endif

   // Pending slot: refilled in IDLE only when the old entry is consumed alongside a new strobe
   always_comb begin
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      if (!ioctl_ram) begin
         pend_d = 1'b0;
      end else if (state_q == ST_IDLE) begin
         pend_d      = pend_q & strobe_s;
         pend_addr_d = (pend_q & strobe_s) ? ioctl_addr : pend_addr_q;
      end else if (strobe_s && !pend_q) begin
         pend_d      = 1'b1;
         pend_addr_d = ioctl_addr;
      end else begin
         pend_d      = pend_q;
         pend_addr_d = pend_addr_q;
      end
   end

   // Main transaction FSM next-state and output values
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ok_d    = 1'b0;
      ovf_d   = ovf_q;
      raddr_d = raddr_q;
      rd_d    = rd_q;
      bsel_d  = bsel_q;
      if (!ioctl_ram) begin
         state_d = ST_IDLE;
         rd_d    = 1'b0;
         ovf_d   = 1'b0;
      end else begin
         ovf_d = (ram_en_q ? ovf_q : 1'b0) | drop_s;
         case (state_q)
            ST_IDLE: begin
               if (take_s) begin
                  if (oor_s) begin
                     data_d  = FILL;
                     state_d = ST_SERVE;
                  end
`ifdef JTFRAME_NVRAM_CACHE_EN
                  else if (hit_s) begin
                     data_d  = take_addr_s[0] ? cdata_q[15:8] : cdata_q[7:0];
                     state_d = ST_SERVE;
                  end
`endif
                  else begin
                     raddr_d = take_addr_s[AW-1:1];
                     bsel_d  = take_addr_s[0];
                     rd_d    = 1'b1;
                     state_d = ST_REQ;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_REQ: begin
               if (ram_ack) begin
                  rd_d    = 1'b0;
                  state_d = ST_WAIT;
               end else begin
                  rd_d    = 1'b1;
               end
            end
            ST_WAIT: begin
               if (ram_dok) begin
                  data_d  = bsel_q ? ram_din[15:8] : ram_din[7:0];
                  state_d = ST_SERVE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
            ST_SERVE: begin
               ok_d    = 1'b1;
               state_d = ST_IDLE;
            end
            default: begin
               rd_d    = 1'b0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

`ifdef JTFRAME_NVRAM_CACHE_EN
   // Cache refills from every accepted RAM word and forgets it on any upload start or stop
   always_comb begin
      cvalid_d = cvalid_q;
      ctag_d   = ctag_q;
      cdata_d  = cdata_q;
      if (ioctl_ram != ram_en_q) begin
         cvalid_d = 1'b0;
      end else if (ioctl_ram && state_q == ST_WAIT && ram_dok) begin
         cvalid_d = 1'b1;
         ctag_d   = raddr_q;
         cdata_d  = ram_din;
      end else begin
         cvalid_d = cvalid_q;
      end
   end
`endif

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         data_q      <= 8'h00;
         ok_q        <= 1'b0;
         ovf_q       <= 1'b0;
         raddr_q     <= '0;
         rd_q        <= 1'b0;
         bsel_q      <= 1'b0;
         pend_q      <= 1'b0;
         pend_addr_q <= 25'd0;
         ram_en_q    <= 1'b0;
`ifdef JTFRAME_NVRAM_CACHE_EN
         cvalid_q    <= 1'b0;
         ctag_q      <= '0;
         cdata_q     <= 16'h0000;
`endif
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         ok_q        <= ok_d;
         ovf_q       <= ovf_d;
         raddr_q     <= raddr_d;
         rd_q        <= rd_d;
         bsel_q      <= bsel_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         ram_en_q    <= ioctl_ram;
`ifdef JTFRAME_NVRAM_CACHE_EN
         cvalid_q    <= cvalid_d;
         ctag_q      <= ctag_d;
         cdata_q     <= cdata_d;
`endif
      end
   end

   assign ioctl_data2sd = data_q;
   assign dump_ok       = ok_q;
   assign dump_ovf      = ovf_q;
   assign ram_addr      = raddr_q;
   assign ram_rd        = rd_q;

endmodule
